// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage. in_ready, out_valid, count and out_data
// are all flop outputs, so no input reaches an output combinationally.
module pipe_skid_stage #(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, pop;

  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !pop)      state_nxt = TWO;
        else if (!accept && pop) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Handshake outputs are decoded from the next state and registered.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != TWO);
      unique case (state_nxt)
        ONE:     count <= 2'd1;
        TWO:     count <= 2'd2;
        default: count <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      unique case (state)
        EMPTY: if (accept) main_q <= in_data;
        ONE: begin
          if (accept && pop) main_q <= in_data;
          else if (accept)   skid_q <= in_data;
        end
        TWO:     if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a reference occupancy model pushes
// accepted payloads; a negedge monitor pops and compares on every transfer.
module tb_pipe_skid_stage;

  logic       clock = 1'b0;
  logic       resetn, in_valid, out_ready, flush;
  logic [7:0] in_data;
  logic       in_ready, out_valid, in_ready_h, out_valid_h;
  logic [7:0] out_data, out_data_h;
  logic [1:0] count, count_h;

  int         n_chk = 0, n_fail = 0;
  int         mcnt = 0;
  bit         mon_en = 1'b0;
  logic [7:0] sbq[$];
  logic [7:0] prev_d;
  bit         hold_prev = 1'b0;

  always #5 clock = ~clock;

  pipe_skid_stage #(.WIDTH(8), .CLEAR_ON_FLUSH(1'b1)) u_dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .count(count));

  pipe_skid_stage #(.WIDTH(8), .CLEAR_ON_FLUSH(1'b0)) u_hold (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_h),
    .in_data(in_data), .out_valid(out_valid_h), .out_ready(out_ready),
    .out_data(out_data_h), .flush(flush), .count(count_h));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy,
                     input logic fl = 1'b0, input logic rn = 1'b1);
    in_valid = v; in_data = d; out_ready = ordy; flush = fl; resetn = rn;
    @(posedge clock);
    #1;
  endtask

  // Reference model: occupancy and accepted payloads, independent of the DUT.
  always @(posedge clock) begin
    if (!resetn || flush) begin
      mcnt = 0;
      sbq.delete();
    end else begin
      int acc, pp;
      acc = (in_valid && mcnt < 2) ? 1 : 0;
      pp  = (mcnt > 0 && out_ready) ? 1 : 0;
      if (acc == 1) sbq.push_back(in_data);
      mcnt = mcnt + acc - pp;
    end
  end

  // Monitor: handshake flags every cycle, payload on every transfer.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("count", {30'd0, count}, mcnt);
      chk("count_hold", {30'd0, count_h}, mcnt);
      chk("out_valid", {31'd0, out_valid}, (mcnt > 0) ? 1 : 0);
      chk("in_ready", {31'd0, in_ready}, (mcnt < 2) ? 1 : 0);
      chk("in_ready_hold", {31'd0, in_ready_h}, (mcnt < 2) ? 1 : 0);
      chk("out_valid_hold", {31'd0, out_valid_h}, (mcnt > 0) ? 1 : 0);
      if (hold_prev) chk("stable", {24'd0, out_data}, {24'd0, prev_d});
      if (mcnt > 0 && out_ready) begin
        if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("payload", {24'd0, out_data}, {24'd0, sbq.pop_front()});
      end
      hold_prev = (mcnt > 0) && !out_ready && !flush && resetn;
      prev_d    = out_data;
    end
  end

  initial begin
    in_valid = 0; in_data = 0; out_ready = 0; flush = 0; resetn = 0;
    @(posedge clock); #1;
    cyc(0, 8'h00, 0, 0, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_count", {30'd0, count}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    mon_en = 1'b1;

    // Single payload latency
    cyc(1, 8'h11, 1);
    chk("lat_valid", {31'd0, out_valid}, 1);
    chk("lat_data", {24'd0, out_data}, 32'h11);
    chk("lat_count", {30'd0, count}, 1);
    cyc(0, 8'h00, 1);

    // Back-to-back stream, no bubbles
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(i), 1);
      chk("b2b_in_ready", {31'd0, in_ready}, 1);
      chk("b2b_data", {24'd0, out_data}, i);
    end
    cyc(0, 8'h00, 1);

    // Fill to two, third held off, then drain in order
    cyc(1, 8'hA1, 0);
    cyc(1, 8'hA2, 0);
    chk("full_count", {30'd0, count}, 2);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    cyc(1, 8'hA3, 0);
    chk("full_main", {24'd0, out_data}, 32'hA1);
    cyc(1, 8'hA3, 1);
    chk("drain_main", {24'd0, out_data}, 32'hA2);
    cyc(1, 8'hA3, 1);
    chk("drain_a3", {24'd0, out_data}, 32'hA3);
    cyc(0, 8'h00, 1);
    chk("drain_count", {30'd0, count}, 0);

    // Flush while full with a payload offered
    cyc(1, 8'hB1, 0);
    cyc(1, 8'hB2, 0);
    cyc(1, 8'h55, 0, 1);
    chk("flush_count", {30'd0, count}, 0);
    chk("flush_valid", {31'd0, out_valid}, 0);
    chk("flush_ready", {31'd0, in_ready}, 1);
    chk("flush_data_clr", {24'd0, out_data}, 0);
    chk("flush_data_hold", {24'd0, out_data_h}, 32'hB1);
    cyc(0, 8'h00, 1);
    chk("flush_no_55", {31'd0, out_valid}, 0);

    // Reset beats flush and pop while full
    cyc(1, 8'hC1, 0);
    cyc(1, 8'hC2, 0);
    cyc(1, 8'hC3, 1, 1, 0);
    chk("rst2_valid", {31'd0, out_valid}, 0);
    chk("rst2_ready", {31'd0, in_ready}, 1);
    chk("rst2_count", {30'd0, count}, 0);
    chk("rst2_data", {24'd0, out_data}, 0);
    chk("rst2_data_hold", {24'd0, out_data_h}, 0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);
    chk("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
